// File: rtl/ct_spsram_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ct_spsram_ctrl_pkg
// Shared definitions for the 4096x32 single-port SRAM controller:
//   - controller state encoding (INIT sweep / RUN service)
//   - default geometry and the byte-lane count
//   - be2wen: active-high byte strobes -> active-low per-bit write enables
// ---------------------------------------------------------------------------
package ct_spsram_ctrl_pkg;

    localparam int CT_ADDR_WIDTH = 12;
    localparam int CT_DATA_WIDTH = 32;
    localparam int BE_WIDTH      = CT_DATA_WIDTH / 8;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

    // A strobed byte lane is written (wen bits 0); an unstrobed lane is
    // masked (wen bits 1), so be=0 produces an all-ones mask.
    function automatic logic [CT_DATA_WIDTH-1:0] be2wen(input logic [BE_WIDTH-1:0] be);
        logic [CT_DATA_WIDTH-1:0] wen;
        wen = {CT_DATA_WIDTH{1'b1}};
        for (int i = 0; i < BE_WIDTH; i++) begin
            wen[8*i +: 8] = {8{~be[i]}};
        end
        return wen;
    endfunction

endpackage

// File: rtl/ct_spsram_rr_arb2.sv
// ---------------------------------------------------------------------------
// ct_spsram_rr_arb2
// Two-way round-robin arbiter. The grant is combinational from the request
// vector and a 1-bit priority flop; after any grant priority moves to the
// other requester, and it holds when nothing is granted.
// Ports:
//   clk, rst : clock and synchronous active-high reset
//   en       : arbitration enable (controller in service mode)
//   req[1:0] : request valids
//   gnt[1:0] : one-hot (or zero) grant vector
// ---------------------------------------------------------------------------
module ct_spsram_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic       prio_r;
    logic [1:0] gnt_s;

    // Grant: a lone requester wins; on contention the prioritised one wins.
    always_comb begin
        gnt_s[0] = en & req[0] & (~req[1] | ~prio_r);
        gnt_s[1] = en & req[1] & (~req[0] |  prio_r);
    end

    // Priority flop: point at the requester that was not just served.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_r <= 1'b0;
        end else if (gnt_s[0]) begin
            prio_r <= 1'b1;
        end else if (gnt_s[1]) begin
            prio_r <= 1'b0;
        end else begin
            prio_r <= prio_r;
        end
    end

    assign gnt = gnt_s;

endmodule

// File: rtl/ct_spsram_4096x32_ctrl.sv
// ---------------------------------------------------------------------------
// ct_spsram_4096x32_ctrl
// Arbiter/sequencer in front of the ct_spsram_4096x32 single-port macro.
// After reset it zero-fills every word, then shares the port between two
// requesters with round-robin priority. All macro pins are registered, so an
// access accepted in cycle N drives the macro in N+1 and read data returns
// (with rsp_vld) in N+2.
// Ports:
//   CLK, RST                       : clock, synchronous active-high reset
//   rN_vld/rdy/wr/addr/wdata/be    : request channel of requester N
//   rN_rsp_vld/rN_rsp_data         : read response of requester N
//   sram_a/cen/gwen/wen/d, sram_q  : macro native pins
//   init_done                      : zero-fill complete, requests serviced
// ---------------------------------------------------------------------------
module ct_spsram_4096x32_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int INIT_EN    = 1,
    parameter int ADDR_WIDTH = CT_ADDR_WIDTH,
    parameter int DATA_WIDTH = CT_DATA_WIDTH
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    r0_vld,
    output logic                    r0_rdy,
    input  logic                    r0_wr,
    input  logic [ADDR_WIDTH-1:0]   r0_addr,
    input  logic [DATA_WIDTH-1:0]   r0_wdata,
    input  logic [DATA_WIDTH/8-1:0] r0_be,
    output logic                    r0_rsp_vld,
    output logic [DATA_WIDTH-1:0]   r0_rsp_data,
    input  logic                    r1_vld,
    output logic                    r1_rdy,
    input  logic                    r1_wr,
    input  logic [ADDR_WIDTH-1:0]   r1_addr,
    input  logic [DATA_WIDTH-1:0]   r1_wdata,
    input  logic [DATA_WIDTH/8-1:0] r1_be,
    output logic                    r1_rsp_vld,
    output logic [DATA_WIDTH-1:0]   r1_rsp_data,
    output logic [ADDR_WIDTH-1:0]   sram_a,
    output logic                    sram_cen,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    output logic [DATA_WIDTH-1:0]   sram_d,
    input  logic [DATA_WIDTH-1:0]   sram_q,
    output logic                    init_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    ctrl_state_e             state_r;
    ctrl_state_e             state_nxt_s;
    logic [ADDR_WIDTH-1:0]   cnt_r;
    logic                    init_done_r;
    logic [1:0]              gnt_s;

    logic                    sel_wr_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic [DATA_WIDTH/8-1:0] sel_be_s;

    logic [ADDR_WIDTH-1:0]   a_nxt_s;
    logic                    cen_nxt_s;
    logic                    gwen_nxt_s;
    logic [DATA_WIDTH-1:0]   wen_nxt_s;
    logic [DATA_WIDTH-1:0]   d_nxt_s;

    logic [ADDR_WIDTH-1:0]   sram_a_r;
    logic                    sram_cen_r;
    logic                    sram_gwen_r;
    logic [DATA_WIDTH-1:0]   sram_wen_r;
    logic [DATA_WIDTH-1:0]   sram_d_r;

    logic                    p1_vld_r;
    logic                    p1_id_r;
    logic                    p2_vld_r;
    logic                    p2_id_r;

    // Arbitration is enabled by init_done, which rises the cycle after the
    // final sweep write is on the pins, so no grant overlaps the sweep.
    ct_spsram_rr_arb2 u_arb (
        .clk (CLK),
        .rst (RST),
        .en  (init_done_r),
        .req ({r1_vld, r0_vld}),
        .gnt (gnt_s)
    );

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= (INIT_EN != 0) ? ST_INIT : ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic: the sweep ends once the last address has been issued.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (cnt_r == LAST_ADDR) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // Sweep address counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_r <= {ADDR_WIDTH{1'b0}};
        end else if (state_r == ST_INIT) begin
            cnt_r <= cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Init-done flag: set one cycle after RUN is entered, then held.
    always_ff @(posedge CLK) begin
        if (RST) begin
            init_done_r <= (INIT_EN == 0);
        end else if (state_r == ST_RUN) begin
            init_done_r <= 1'b1;
        end else begin
            init_done_r <= init_done_r;
        end
    end

    // Request field mux for the granted requester.
    always_comb begin
        if (gnt_s[1]) begin
            sel_wr_s    = r1_wr;
            sel_addr_s  = r1_addr;
            sel_wdata_s = r1_wdata;
            sel_be_s    = r1_be;
        end else begin
            sel_wr_s    = r0_wr;
            sel_addr_s  = r0_addr;
            sel_wdata_s = r0_wdata;
            sel_be_s    = r0_be;
        end
    end

    // Output logic: next macro pin values. Address and data hold while idle.
    always_comb begin
        a_nxt_s    = sram_a_r;
        d_nxt_s    = sram_d_r;
        cen_nxt_s  = 1'b1;
        gwen_nxt_s = 1'b1;
        wen_nxt_s  = {DATA_WIDTH{1'b1}};
        case (state_r)
            ST_INIT: begin
                a_nxt_s    = cnt_r;
                d_nxt_s    = {DATA_WIDTH{1'b0}};
                cen_nxt_s  = 1'b0;
                gwen_nxt_s = 1'b0;
                wen_nxt_s  = {DATA_WIDTH{1'b0}};
            end
            ST_RUN: begin
                if (|gnt_s) begin
                    a_nxt_s   = sel_addr_s;
                    cen_nxt_s = 1'b0;
                    if (sel_wr_s) begin
                        gwen_nxt_s = 1'b0;
                        wen_nxt_s  = be2wen(sel_be_s);
                        d_nxt_s    = sel_wdata_s;
                    end else begin
                        gwen_nxt_s = 1'b1;
                        wen_nxt_s  = {DATA_WIDTH{1'b1}};
                    end
                end else begin
                    cen_nxt_s  = 1'b1;
                    gwen_nxt_s = 1'b1;
                end
            end
            default: begin
                cen_nxt_s  = 1'b1;
                gwen_nxt_s = 1'b1;
            end
        endcase
    end

    // Registered macro drive.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sram_a_r    <= {ADDR_WIDTH{1'b0}};
            sram_cen_r  <= 1'b1;
            sram_gwen_r <= 1'b1;
            sram_wen_r  <= {DATA_WIDTH{1'b1}};
            sram_d_r    <= {DATA_WIDTH{1'b0}};
        end else begin
            sram_a_r    <= a_nxt_s;
            sram_cen_r  <= cen_nxt_s;
            sram_gwen_r <= gwen_nxt_s;
            sram_wen_r  <= wen_nxt_s;
            sram_d_r    <= d_nxt_s;
        end
    end

    // Read response pipeline: stage 1 tracks the pin cycle, stage 2 the Q cycle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            p1_vld_r <= 1'b0;
            p1_id_r  <= 1'b0;
            p2_vld_r <= 1'b0;
            p2_id_r  <= 1'b0;
        end else begin
            p1_vld_r <= (|gnt_s) & ~sel_wr_s;
            p1_id_r  <= gnt_s[1];
            p2_vld_r <= p1_vld_r;
            p2_id_r  <= p1_id_r;
        end
    end

    assign r0_rdy      = gnt_s[0];
    assign r1_rdy      = gnt_s[1];
    assign r0_rsp_vld  = p2_vld_r & ~p2_id_r;
    assign r1_rsp_vld  = p2_vld_r &  p2_id_r;
    assign r0_rsp_data = sram_q;
    assign r1_rsp_data = sram_q;
    assign sram_a      = sram_a_r;
    assign sram_cen    = sram_cen_r;
    assign sram_gwen   = sram_gwen_r;
    assign sram_wen    = sram_wen_r;
    assign sram_d      = sram_d_r;
    assign init_done   = init_done_r;

endmodule

// File: doc/ct_spsram_4096x32_ctrl.md
# ct_spsram_4096x32_ctrl

Two-requester arbiter and sequencer for the 4096x32 single-port SRAM macro (`ct_spsram_4096x32`). After reset it zero-fills all 4096 words, then shares the single port between requesters 0 and 1 with round-robin priority. It expands per-byte strobes into the macro's active-low bit write-enables and routes one-beat read responses back to the issuing requester. It sits between the macro and its two clients; the macro keeps its native pins (A, CEN, GWEN, WEN, D, Q).

## Interface

Parameters:
- `INIT_EN`, 1: perform the zero-fill sweep after reset; 0 enters RUN directly.
- `ADDR_WIDTH`, 12: word address width (depth = 2^ADDR_WIDTH).
- `DATA_WIDTH`, 32: data width; must be a multiple of 8.

Ports (one clock, `CLK`; reset `RST` is synchronous and active-high):
- `CLK`  in  1  clock; also drives the macro's CLK.
- `RST`  in  1  synchronous active-high reset.
- `r0_vld` / `r1_vld`  in  1  request valid.
- `r0_rdy` / `r1_rdy`  out  1  request accepted this cycle.
- `r0_wr` / `r1_wr`  in  1  1 = write, 0 = read.
- `r0_addr` / `r1_addr`  in  12  word address.
- `r0_wdata` / `r1_wdata`  in  32  write data.
- `r0_be` / `r1_be`  in  4  byte strobes, active-high; bit i covers data[8i+7:8i].
- `r0_rsp_vld` / `r1_rsp_vld`  out  1  read data valid, one-cycle pulse; no backpressure.
- `r0_rsp_data` / `r1_rsp_data`  out  32  read data.
- `sram_a`  out  12  to macro A.
- `sram_cen`  out  1  to macro CEN, active-low.
- `sram_gwen`  out  1  to macro GWEN, active-low.
- `sram_wen`  out  32  to macro WEN, active-low per bit.
- `sram_d`  out  32  to macro D.
- `sram_q`  in  32  from macro Q.
- `init_done`  out  1  high once the sweep completes (or immediately if INIT_EN=0).

## Operation

- **States.**
  - INIT: entered on RST when INIT_EN=1.
  - RUN: entered when INIT finishes, or on RST when INIT_EN=0.
- **INIT.**
  - An address counter walks 0..4095, one word per cycle.
  - Each cycle the macro is driven with cen=0, gwen=0, wen=0, d=0.
  - Both rdy are held at 0.
  - After the write at address 4095 is issued, the block moves to RUN and `init_done` goes high.
  - INIT lasts exactly 4096 cycles.
- **RUN arbitration.**
  - Ready is combinational: `rN_rdy = RUN & rN_vld & (no competing valid | prio == N)`.
  - At most one rdy is high per cycle.
  - A request is accepted when vld & rdy.
  - `prio` is a 1-bit register, reset value 0. After any grant it points to the other requester. It is unchanged in cycles with no grant.
- **Macro drive.**
  - All sram_* outputs are registered; the accepted request is presented on the following cycle.
  - Write: cen=0, gwen=0, `wen[8i+7:8i] = {8{~be[i]}}`, d=wdata.
  - A write with be=0 still occupies the port with cen=0 and gwen=0, but all wen bits are 1, so no bits change.
  - Read: cen=0, gwen=1, wen=all ones.
  - With no grant, cen=1 and gwen=1.
- **Response routing.**
  - A 2-stage pipeline carries {valid, requester id} for reads only.
  - `rN_rsp_data = sram_q` is a combinational pass-through; it is meaningful only while `rN_rsp_vld` is high.
- **RST mid-operation.**
  - RST in any state returns to INIT (or RUN if INIT_EN=0) with the counter at 0.
  - In-flight responses are discarded: the pipeline is cleared and rsp_vld stays 0.
- **Reset values.**
  - sram_cen=1, sram_gwen=1, sram_wen=all ones, sram_a=0, sram_d=0.
  - rsp_vld=0, init_done=0 if INIT_EN=1.
  - rdy=0 while in INIT.

## Timing

- Accept in cycle N → macro pins driven in N+1 → macro samples at the end of N+1 → `rsp_vld` and Q valid in N+2. Read latency is 2 cycles.
- Throughput is one access per cycle. Back-to-back grants alternate between requesters when both are valid.
- A write accepted in N followed by a read of the same address accepted in N+1 returns the new data. The macro applies writes in order.
- RST asserted in cycle N: state is reset at the N edge. The first INIT write is driven on the macro in N+1.
- The first RUN grant can occur in the cycle after the final INIT write is driven.

## Structure

- Shared package `ct_spsram_ctrl_pkg`:
  - state enum {INIT, RUN};
  - `BE_WIDTH = DATA_WIDTH/8`;
  - function `be2wen` (byte strobe to active-low bit mask).
- Sub-module `ct_spsram_rr_arb2`: 2-way round-robin arbiter holding the `prio` flop; outputs grant vector.
- The top level holds the FSM, init counter, registered macro drive and response pipeline. It does not instantiate the macro; the macro is instantiated alongside this block.

## Test plan

- Reset with INIT_EN=1:
  - cen=0 with a incrementing 0→4095 over 4096 cycles;
  - `init_done` rises on the following cycle;
  - a subsequent read of 0x7FF returns 0x00000000.
- r0 writes 0xDEADBEEF to 0x010 with be=0xF; r1 then reads 0x010:
  - r1_rsp_vld pulses 2 cycles after r1's accept;
  - data is 0xDEADBEEF;
  - r0_rsp_vld never pulses.
- Byte-strobe write of 0x11223344 to 0x010 with be=0x5:
  - sram_wen=0xFF00FF00;
  - a read of 0x010 returns 0xDE22BE44.
- Both requesters hold vld high for 6 cycles:
  - grants alternate r0,r1,r0,r1,r0,r1;
  - each response returns to its own requester, in order.
- RST pulsed while a read is in flight and mid-INIT at address 0x200:
  - no rsp_vld appears;
  - the sweep restarts at address 0;
  - rdy stays 0 until the sweep completes.
